// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: programmable serial sequence-detection controller.
// Holds a pattern of 1..MAX_LEN bits, an overlap mode and a match threshold.
// It runs detection over a valid-qualified bit stream, counts matches and
// reports completion. Every output is driven directly from a flop.
module seq_det_ctrl #(
  parameter  int unsigned MAX_LEN = 8,
  parameter  int unsigned CNT_W   = 8,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_thresh,
  input  logic               start,
  input  logic               stop,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               busy,
  output logic               det,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // Reset configuration: 10110, overlapping, stop after the first match.
  localparam logic [MAX_LEN-1:0] DEF_PAT    = MAX_LEN'(5'b10110);
  localparam logic [LEN_W-1:0]   DEF_LEN    = LEN_W'((MAX_LEN < 5) ? MAX_LEN : 5);
  localparam logic [CNT_W-1:0]   DEF_THRESH = CNT_W'(1);

  state_t             r_state;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [CNT_W-1:0]   r_thresh;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_det;
  logic               r_done;
  logic               r_err;

  logic [MAX_LEN-1:0] w_hist_n;
  logic [LEN_W-1:0]   w_fill_n;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_match;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_cfg_ok;
  logic               w_hit_thresh;

  // Next history/fill, active-length mask and match/threshold decode.
  always_comb begin
    w_hist_n = {r_hist[MAX_LEN-2:0], in_bit};
    w_fill_n = (r_fill >= r_len) ? r_len : r_fill + LEN_W'(1);
    w_mask   = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < 32'(r_len));
    end
    w_match      = (w_fill_n == r_len) && (((w_hist_n ^ r_pattern) & w_mask) == '0);
    w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
    w_cfg_ok     = (cfg_len != '0) && (32'(cfg_len) <= MAX_LEN);
    w_hit_thresh = (r_thresh != '0) && (w_cnt_inc == r_thresh);
  end

  // Control FSM with configuration register file and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pattern <= DEF_PAT;
      r_len     <= DEF_LEN;
      r_overlap <= 1'b1;
      r_thresh  <= DEF_THRESH;
      r_hist    <= '0;
      r_fill    <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_det     <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_det <= 1'b0;
      r_err <= 1'b0;

      if (cfg_we) begin
        if ((r_state != S_RUN) && w_cfg_ok) begin
          r_pattern <= cfg_pattern;
          r_len     <= cfg_len;
          r_overlap <= cfg_overlap;
          r_thresh  <= cfg_thresh;
        end else begin
          r_err <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_hist  <= '0;
            r_fill  <= '0;
            r_done  <= 1'b0;
          end
        end
        S_RUN: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_hist  <= '0;
            r_fill  <= '0;
          end else if (in_valid) begin
            r_hist <= w_hist_n;
            r_fill <= w_fill_n;
            if (w_match) begin
              r_det <= 1'b1;
              r_cnt <= w_cnt_inc;
              if (!r_overlap) begin
                r_fill <= '0;
              end
              if (w_hit_thresh) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end else if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_hist  <= '0;
            r_fill  <= '0;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign det       = r_det;
  assign match_cnt = r_cnt;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl.
module tb_seq_det_ctrl;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk;
  logic               rst;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_thresh;
  logic               start;
  logic               stop;
  logic               in_valid;
  logic               in_bit;
  logic               busy;
  logic               det;
  logic [CNT_W-1:0]   match_cnt;
  logic               done;
  logic               err;

  int n_tests = 0;
  int n_fail  = 0;

  seq_det_ctrl #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cfg_thresh (cfg_thresh),
    .start      (start),
    .stop       (stop),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .busy       (busy),
    .det        (det),
    .match_cnt  (match_cnt),
    .done       (done),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                     input logic ovl, input logic [CNT_W-1:0] thr);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_thresh  = thr;
    cfg_we      = 1'b1;
    tick();
    cfg_we      = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    logic [7:0]  s8;
    logic [12:0] s13;

    rst = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_thresh = '0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_bit = 1'b0;

    // Reset asserted mid-cycle, checked while held and after release
    #12 rst = 1'b1;
    #1;
    check("rst_hold_busy", busy, 0);
    check("rst_hold_done", done, 0);
    #9 rst = 1'b0;
    tick();
    check("rst_busy", busy, 0);
    check("rst_det", det, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cnt", match_cnt, 0);

    // Default config: 10110, threshold 1
    pulse_start();
    check("def_busy", busy, 1);
    send(1); send(0); send(1); send(1);
    check("def_det_b4", det, 0);
    send(0);
    check("def_det_b5", det, 1);
    check("def_cnt", match_cnt, 1);
    check("def_done", done, 1);
    check("def_busy_end", busy, 0);
    tick();
    check("def_det_pulse", det, 0);

    // Overlapping, run until stop
    cfg(8'b0001_0110, 4'd5, 1'b1, 8'd0);
    check("ovl_cfg_err", err, 0);
    pulse_start();
    check("ovl_busy", busy, 1);
    check("ovl_done_clr", done, 0);
    check("ovl_cnt_clr", match_cnt, 0);
    s8 = 8'b1011_0110;
    for (int i = 0; i < 8; i++) begin
      send(s8[7-i]);
      check($sformatf("ovl_det_b%0d", i + 1), det, (i == 4 || i == 7) ? 1 : 0);
    end
    check("ovl_cnt", match_cnt, 2);
    check("ovl_busy_run", busy, 1);
    pulse_stop();
    check("ovl_stop_busy", busy, 0);
    check("ovl_stop_cnt", match_cnt, 2);

    // Non-overlapping; in_valid in the start cycle must be ignored
    cfg(8'b0001_0110, 4'd5, 1'b0, 8'd0);
    start = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    s13 = 13'b1_0110_1101_0110;
    for (int i = 0; i < 13; i++) begin
      send(s13[12-i]);
      check($sformatf("novl_det_b%0d", i + 1), det, (i == 4 || i == 12) ? 1 : 0);
    end
    check("novl_cnt", match_cnt, 2);
    pulse_stop();

    // Threshold 2 -> DONE, then further bits ignored
    cfg(8'b0001_0110, 4'd5, 1'b1, 8'd2);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      send(s8[7-i]);
    end
    check("thr_det", det, 1);
    check("thr_done", done, 1);
    check("thr_busy", busy, 0);
    check("thr_cnt", match_cnt, 2);
    send(1); send(0); send(1); send(1); send(0);
    check("thr_post_det", det, 0);
    check("thr_post_cnt", match_cnt, 2);
    check("thr_post_done", done, 1);

    // Rejected config writes: len 0, len > MAX_LEN, write during RUN
    cfg(8'hFF, 4'd0, 1'b1, 8'd1);
    check("err_len0", err, 1);
    tick();
    check("err_len0_pulse", err, 0);
    cfg(8'hFF, 4'd9, 1'b1, 8'd1);
    check("err_len9", err, 1);
    pulse_start();
    check("err_run_busy", busy, 1);
    cfg(8'h07, 4'd3, 1'b1, 8'd1);
    check("err_run", err, 1);
    send(1); send(0); send(1); send(1); send(0);
    check("err_old_det", det, 1);
    check("err_old_cnt", match_cnt, 1);
    check("err_old_busy", busy, 1);

    // stop + start together: stop wins (from RUN and from IDLE)
    stop = 1'b1; start = 1'b1;
    tick();
    check("coll_run_busy", busy, 0);
    check("coll_run_cnt", match_cnt, 1);
    tick();
    stop = 1'b0; start = 1'b0;
    check("coll_idle_busy", busy, 0);

    // Full-length pattern
    cfg(8'b1100_1010, 4'd8, 1'b1, 8'd1);
    check("max_cfg_err", err, 0);
    pulse_start();
    s8 = 8'b1100_1010;
    for (int i = 0; i < 8; i++) begin
      send(s8[7-i]);
      check($sformatf("max_det_b%0d", i + 1), det, (i == 7) ? 1 : 0);
    end
    check("max_done", done, 1);

    // Reset mid-run after bit 3 of a match; config reverts to default
    cfg(8'b0000_0011, 4'd4, 1'b1, 8'd0);
    pulse_start();
    send(0); send(0); send(1);
    #2 rst = 1'b1;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_cnt", match_cnt, 0);
    #2 rst = 1'b0;
    send(1);
    check("mrst_no_det", det, 0);
    pulse_start();
    send(1); send(0); send(1); send(1); send(0);
    check("mrst_def_det", det, 1);
    check("mrst_def_done", done, 1);
    check("mrst_def_cnt", match_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Bound on total runtime so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion, expected finish");
    $fatal(1, "timeout");
  end

endmodule
